// File: rtl/cmp_sched_pkg.sv
// Shared types and constants for the comparator scheduler: FSM states, op encodings,
// condition codes, flag bit positions and the condition evaluator.
package cmp_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam logic OP_CMP  = 1'b0;
  localparam logic OP_LOAD = 1'b1;

  localparam logic [2:0] COND_EQ     = 3'd0;
  localparam logic [2:0] COND_NE     = 3'd1;
  localparam logic [2:0] COND_LT     = 3'd2;
  localparam logic [2:0] COND_GT     = 3'd3;
  localparam logic [2:0] COND_LE     = 3'd4;
  localparam logic [2:0] COND_GE     = 3'd5;
  localparam logic [2:0] COND_ALWAYS = 3'd6;
  localparam logic [2:0] COND_NEVER  = 3'd7;

  localparam int FLAG_EQ = 0;
  localparam int FLAG_NE = 1;
  localparam int FLAG_LT = 2;
  localparam int FLAG_GT = 3;

  function automatic logic cond_eval(input logic [2:0] cond, input logic [3:0] flags);
    logic t;
    t = 1'b0;
    case (cond)
      COND_EQ:     t = flags[FLAG_EQ];
      COND_NE:     t = flags[FLAG_NE];
      COND_LT:     t = flags[FLAG_LT];
      COND_GT:     t = flags[FLAG_GT];
      COND_LE:     t = flags[FLAG_EQ] | flags[FLAG_LT];
      COND_GE:     t = flags[FLAG_EQ] | flags[FLAG_GT];
      COND_ALWAYS: t = 1'b1;
      default:     t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/cmp_sched_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, pointer advances on adv.
// The pointer remembers the last winner; reset marks requester 1 as last so requester 0 leads.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt,
  output logic       last
);

  logic last_q, last_d;

  always_comb begin
    if (req == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
    else              gnt = req;
    last_d = last_q;
    if (adv && (|gnt)) last_d = gnt[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

  assign last = last_q;

endmodule

// File: rtl/cmp_sched.sv
// Two-requester scheduler for a shared comparator: IDLE -> ISSUE -> RESP, one op per 3 cycles.
// Condition evaluation (rsp_taken) is built only when CMP_SCHED_COND_EN is defined.
module cmp_sched
  import cmp_sched_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic             op0,
  input  logic             op1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [2:0]       cond0,
  input  logic [2:0]       cond1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             cmp_compare,
  output logic             cmp_load,
  output logic [WIDTH-1:0] cmp_bus1,
  output logic [WIDTH-1:0] cmp_bus2,
  input  logic [WIDTH-1:0] cmp_flags,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_flags,
  output logic             rsp_taken
);

  state_t           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             cmp_compare_q, cmp_compare_d;
  logic             cmp_load_q, cmp_load_d;
  logic [WIDTH-1:0] bus1_q, bus1_d;
  logic [WIDTH-1:0] bus2_q, bus2_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             id_q, id_d;
  logic [1:0]       arb_gnt;
  logic             arb_adv;
  logic             arb_last_unused;
  logic             win;
  logic             win_op;
`ifdef CMP_SCHED_COND_EN
  logic [2:0]       cond_q, cond_d;
`endif

  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .adv  (arb_adv),
    .gnt  (arb_gnt),
    .last (arb_last_unused)
  );

  assign win    = arb_gnt[1];
  assign win_op = win ? op1 : op0;

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    busy_d        = busy_q;
    cmp_compare_d = cmp_compare_q;
    cmp_load_d    = cmp_load_q;
    bus1_d        = bus1_q;
    bus2_d        = bus2_q;
    rsp_valid_d   = rsp_valid_q;
    id_d          = id_q;
    arb_adv       = 1'b0;
`ifdef CMP_SCHED_COND_EN
    cond_d        = cond_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d       = ST_ISSUE;
          gnt_d         = arb_gnt;
          busy_d        = 1'b1;
          id_d          = win;
          cmp_compare_d = (win_op == OP_CMP);
          cmp_load_d    = (win_op == OP_LOAD);
          bus1_d        = win ? a1 : a0;
          bus2_d        = win ? b1 : b0;
          arb_adv       = 1'b1;
`ifdef CMP_SCHED_COND_EN
          cond_d        = win ? cond1 : cond0;
`endif
        end
      end
      ST_ISSUE: begin
        // Comparator registers its flags on this edge, so they are valid throughout RESP.
        state_d       = ST_RESP;
        cmp_compare_d = 1'b0;
        cmp_load_d    = 1'b0;
        rsp_valid_d   = 1'b1;
      end
      ST_RESP: begin
        state_d     = ST_IDLE;
        gnt_d       = 2'b00;
        busy_d      = 1'b0;
        rsp_valid_d = 1'b0;
      end
      default: begin
        state_d       = ST_IDLE;
        gnt_d         = 2'b00;
        busy_d        = 1'b0;
        cmp_compare_d = 1'b0;
        cmp_load_d    = 1'b0;
        rsp_valid_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      gnt_q         <= 2'b00;
      busy_q        <= 1'b0;
      cmp_compare_q <= 1'b0;
      cmp_load_q    <= 1'b0;
      bus1_q        <= '0;
      bus2_q        <= '0;
      rsp_valid_q   <= 1'b0;
      id_q          <= 1'b0;
`ifdef CMP_SCHED_COND_EN
      cond_q        <= 3'd0;
`endif
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      busy_q        <= busy_d;
      cmp_compare_q <= cmp_compare_d;
      cmp_load_q    <= cmp_load_d;
      bus1_q        <= bus1_d;
      bus2_q        <= bus2_d;
      rsp_valid_q   <= rsp_valid_d;
      id_q          <= id_d;
`ifdef CMP_SCHED_COND_EN
      cond_q        <= cond_d;
`endif
    end
  end

  assign gnt         = gnt_q;
  assign busy        = busy_q;
  assign cmp_compare = cmp_compare_q;
  assign cmp_load    = cmp_load_q;
  assign cmp_bus1    = bus1_q;
  assign cmp_bus2    = bus2_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_valid_q ? id_q : 1'b0;
  assign rsp_flags   = rsp_valid_q ? cmp_flags : '0;

`ifdef CMP_SCHED_COND_EN
  assign rsp_taken = rsp_valid_q & cond_eval(cond_q, cmp_flags[3:0]);
`else
  logic unused_cond;
  assign unused_cond = ^{cond0, cond1};
  assign rsp_taken   = 1'b0;
`endif

endmodule

// File: doc/cmp_sched.md
CMP_SCHED -- requirements
Module: cmp_sched

Interface
REQ-001 Parameter: WIDTH, default 16, operand/flag bus width; it SHALL match the comparator bus width.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 req  in  2  per-requester request; bit i = requester i; held until that requester's rsp_valid cycle.
REQ-005 op0, op1  in  1 each  0 = compare, 1 = load flags from operand A.
REQ-006 a0, b0, a1, b1  in  WIDTH each  operands A/B per requester.
REQ-007 cond0, cond1  in  3 each  branch condition code per requester.
REQ-008 gnt  out  2  one-hot owner indication, high during ISSUE and RESP.
REQ-009 busy  out  1  high whenever state is not IDLE.
REQ-010 cmp_compare, cmp_load  out  1 each  comparator control strobes.
REQ-011 cmp_bus1, cmp_bus2  out  WIDTH each  comparator operand buses.
REQ-012 cmp_flags  in  WIDTH  comparator registered flag output (bit0 EQ, bit1 NE, bit2 LT, bit3 GT, unsigned).
REQ-013 rsp_valid  out  1  one-cycle response strobe.
REQ-014 rsp_id  out  1  index of the served requester.
REQ-015 rsp_flags  out  WIDTH  flag word for the served operation.
REQ-016 rsp_taken  out  1  condition result.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE and RESP, with transitions IDLE->ISSUE (any req bit high), ISSUE->RESP (unconditional) and RESP->IDLE (unconditional).
REQ-018 On the IDLE->ISSUE edge, the block SHALL latch the winner's op, operands, cond and id into internal registers.
REQ-019 Arbitration SHALL be round-robin: with a single request, that requester wins; with both, the requester not served last wins; after reset, requester 0 has priority.
REQ-020 In ISSUE, exactly one of cmp_compare (op=0) or cmp_load (op=1) SHALL be high, with cmp_bus1 = latched A and cmp_bus2 = latched B.
REQ-021 Outside ISSUE, cmp_compare and cmp_load SHALL be 0 and cmp_bus1/cmp_bus2 SHALL hold their last latched values.
REQ-022 In RESP: rsp_valid = 1; rsp_flags = cmp_flags; rsp_id = latched id; rsp_taken = cond applied to cmp_flags.
REQ-023 Latency SHALL be: req sampled at edge N, rsp_valid high during the cycle after edge N+1; throughput is one operation per 3 cycles.
REQ-024 Condition codes SHALL be: 0 EQ = f0; 1 NE = f1; 2 LT = f2; 3 GT = f3; 4 LE = f0|f2; 5 GE = f0|f3; 6 ALWAYS = 1; 7 NEVER = 0.
REQ-025 A load operation SHALL evaluate cond on the loaded flag word.
REQ-026 req changes during ISSUE or RESP SHALL be ignored; a dropped request SHALL still complete and pulse rsp_valid.
REQ-027 A req bit still high in IDLE after its own RESP SHALL be treated as a new request, and round-robin then favours the other requester if it is pending.

Reset
REQ-028 rst SHALL force asynchronously: state IDLE, gnt = 0, busy = 0, cmp_compare = 0, cmp_load = 0, cmp_bus1/cmp_bus2 = 0, rsp_valid = 0, rsp_id = 0, rsp_flags = 0, rsp_taken = 0, round-robin pointer favouring requester 0.
REQ-029 rst asserted during ISSUE or RESP SHALL abort the operation with no rsp_valid; comparator flag contents are then undefined to requesters.

Configuration
REQ-030 The macro CMP_SCHED_COND_EN SHALL control condition evaluation: when defined, cond0/cond1 are latched and rsp_taken is per REQ-024; when undefined, cond inputs are ignored, no cond register is built and rsp_taken is constant 0.

Structure
REQ-031 Package cmp_sched_pkg SHALL hold the state enum, op encodings (OP_CMP, OP_LOAD), the 3-bit condition code constants and flag bit indices (FLAG_EQ, FLAG_NE, FLAG_LT, FLAG_GT).
REQ-032 Sub-module rr_arb2 (2-way round-robin arbiter: req, advance strobe, one-hot grant, last pointer) SHALL be instantiated once.

Verification
REQ-033 req=01, op0=0, a0=5, b0=9, cond0=LT -> cmp_compare high in ISSUE; rsp_valid 2 cycles later; rsp_id=0; rsp_flags=0x0006; rsp_taken=1.
REQ-034 req=11 held continuously -> service order 0,1,0,1 with gnt alternating; each rsp_valid 3 cycles apart.
REQ-035 req=10, op1=1, a1=0x0009, cond1=GE -> cmp_load pulse; rsp_flags=0x0009; rsp_taken=1.
REQ-036 rst asserted in the ISSUE cycle -> all outputs 0 immediately, no rsp_valid; next req=01 is served normally.
REQ-037 Build without CMP_SCHED_COND_EN, a0=b0=7, cond0=EQ -> rsp_flags=0x0001, rsp_taken=0.
REQ-038 req0 dropped during ISSUE -> rsp_valid still pulses for id 0; FSM returns to IDLE.
